// File: rtl/priority_arbiter_4ch.sv
// priority_arbiter_4ch
//   Shares one downstream resource among four requesters. Highest index wins
//   (req[3] highest), a grant is held while its request stays high, a grant is
//   forced off after MAX_HOLD cycles, and aging promotes a requester that has
//   been bypassed MAX_WAIT times so low indices cannot starve.
//   gnt_id drives the shared datapath mux select.
//
//   state | meaning
//   IDLE  | no grant; arbitrate when enabled and a candidate exists
//   GRANT | grant held; hold_cnt counts cycles of this grant
//   GAP   | one turnaround cycle between grants; arbitrates like IDLE
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   enables new grants (a grant in progress is not affected)
//   req[3:0]   in   request levels, held until served
//   gnt[3:0]   out  one-hot registered grant
//   gnt_id     out  binary index of gnt, 0 when no grant
//   gnt_valid  out  any grant active
//   promoted   out  current grant came from aging
//   timeout    out  one-cycle pulse in the GAP that follows a forced release
module priority_arbiter_4ch #(
  parameter int MAX_WAIT = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       promoted,
  output logic       timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt [4];
  logic [HW-1:0] hold_cnt;
  logic [3:0]    mask;

  logic [3:0] cand;
  logic [3:0] aged;
  logic [1:0] win_id;
  logic       win_promo;
  logic       do_arb;

  // mask is only ever non-zero during GAP, so it can be applied unconditionally
  always_comb begin
    cand      = req & ~mask;
    aged      = '0;
    win_id    = '0;
    win_promo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      aged[i] = cand[i] && (wait_cnt[i] == WW'(MAX_WAIT));
    end
    win_promo = |aged;
    for (int i = 0; i < 4; i++) begin
      if (win_promo ? aged[i] : cand[i]) win_id = 2'(i);
    end
    do_arb = en && (|cand) && (state != GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      promoted  <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      mask      <= '0;
      for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          // exclusion lasts for the GAP decision only, granted or not
          mask <= '0;
          if (do_arb) begin
            state     <= GRANT;
            gnt       <= 4'b0001 << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            promoted  <= win_promo;
            hold_cnt  <= HW'(1);
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == win_id)
                wait_cnt[i] <= '0;
              else if (req[i])
                wait_cnt[i] <= (wait_cnt[i] == WW'(MAX_WAIT)) ? wait_cnt[i]
                                                               : wait_cnt[i] + 1'b1;
              else
                wait_cnt[i] <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // release wins over a coincident hold limit
          if (!req[gnt_id] || hold_cnt == HW'(MAX_HOLD)) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            promoted  <= 1'b0;
            if (req[gnt_id]) begin
              timeout <= 1'b1;
              mask    <= gnt;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
